// File: rtl/ms_tick_timer.sv
// Millisecond tick timer: synchronises the 1 kHz divided clock, emits one tick per rising edge
// and runs a start/busy/done down-counter. Optional macro TIMER_AUTORELOAD_EN enables periodic mode.
module ms_tick_timer #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 tick_in,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] duration,
   input  logic                 cancel,
   output logic                 tick_pulse,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] remaining
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t state;
   logic   s1, s2, s3;
   logic   tick_evt;

`ifdef TIMER_AUTORELOAD_EN
   logic [CNT_WIDTH-1:0] reload;
`endif

   // s1/s2 form the synchroniser, s3 holds the previous synced level for edge detection
   assign tick_evt = s2 & ~s3;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         tick_pulse <= 1'b0;
      end else begin
         s1         <= tick_in;
         s2         <= s1;
         s3         <= s2;
         tick_pulse <= tick_evt;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
         reload    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (start) begin
`ifdef TIMER_AUTORELOAD_EN
                  reload <= duration;
`endif
                  if (duration != '0) begin
                     state     <= ST_RUN;
                     remaining <= duration;
                     busy      <= 1'b1;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (cancel) begin
                  state     <= ST_IDLE;
                  remaining <= '0;
                  busy      <= 1'b0;
               end else if (tick_evt) begin
                  if (remaining == ONE) begin
                     state     <= ST_DONE;
                     remaining <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     remaining <= remaining - ONE;
                  end
               end
            end
            ST_DONE: begin
`ifdef TIMER_AUTORELOAD_EN
               if (!cancel && reload != '0) begin
                  state     <= ST_RUN;
                  remaining <= reload;
                  busy      <= 1'b1;
               end else begin
                  state     <= ST_IDLE;
                  remaining <= '0;
                  busy      <= 1'b0;
               end
`else
               state <= ST_IDLE;
               busy  <= 1'b0;
`endif
            end
            default: begin
               state     <= ST_IDLE;
               remaining <= '0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ms_tick_timer.sv
// Randomised bench for ms_tick_timer: behavioural model checked every cycle plus directed literal checks.
module tb_ms_tick_timer;

   logic        clock = 1'b0;
   logic        reset_n, tick_in, start, cancel;
   logic [15:0] duration;
   logic        tick_pulse, busy, done;
   logic [15:0] remaining;

   always #5 clock = ~clock;

   ms_tick_timer #(.CNT_WIDTH(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .tick_in    (tick_in),
      .start      (start),
      .duration   (duration),
      .cancel     (cancel),
      .tick_pulse (tick_pulse),
      .busy       (busy),
      .done       (done),
      .remaining  (remaining)
   );

   int checks = 0;
   int errors = 0;

   bit hist[$];
   bit m_running, m_done, m_tick;
   int m_rem, m_reload;
   bit auto_tick;
   int tick_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input bit rn, input bit st, input bit cn, input int dur);
      bit was_done;
      hist.push_back(rn ? tick_in : 1'b0);
      if (hist.size() > 8) void'(hist.pop_front());
      m_tick   = rn && hist[$-2] && !hist[$-3];
      was_done = m_done;
      m_done   = 1'b0;
      if (!rn) begin
         m_running = 1'b0;
         m_rem     = 0;
         m_reload  = 0;
      end else if (m_running) begin
         if (cn) begin
            m_running = 1'b0;
            m_rem     = 0;
         end else if (m_tick) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_running = 1'b0;
               m_done    = 1'b1;
            end
         end
      end else if (was_done) begin
`ifdef TIMER_AUTORELOAD_EN
         if (!cn && m_reload != 0) begin
            m_running = 1'b1;
            m_rem     = m_reload;
         end
`endif
      end else if (st) begin
         m_reload = dur;
         if (dur != 0) begin
            m_running = 1'b1;
            m_rem     = dur;
         end else begin
            m_done = 1'b1;
         end
      end
   endtask

   task automatic step(input bit rn, input bit st, input bit cn, input int dur);
      @(negedge clock);
      reset_n  = rn;
      start    = st;
      cancel   = cn;
      duration = 16'(dur);
      if (auto_tick) begin
         tick_cnt++;
         if (tick_cnt >= 10) begin
            tick_cnt = 0;
            tick_in  = ~tick_in;
         end
      end
      @(posedge clock);
      model_update(rn, st, cn, dur);
      #1;
      chk("tick_pulse", tick_pulse, m_tick);
      chk("busy",       busy,       m_running);
      chk("done",       done,       m_done);
      chk("remaining",  remaining,  m_rem);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int prev, decs, ndone, nticks;
      bit injected, found;
      reset_n = 1'b0; start = 1'b0; cancel = 1'b0; duration = '0; tick_in = 1'b0;
      repeat (4) hist.push_back(1'b0);
      m_running = 0; m_done = 0; m_tick = 0; m_rem = 0; m_reload = 0;
      auto_tick = 1'b1;
      tick_cnt  = 8;

      // Reset with tick_in toggling
      repeat (3) step(0, 1, 0, 5);
      chk("rst_tick_pulse", tick_pulse, 0);
      chk("rst_busy",       busy,       0);
      chk("rst_done",       done,       0);
      chk("rst_remaining",  remaining,  0);
      step(1, 0, 0, 0);
      chk("post_rst_pulse", tick_pulse, 0);

      // Single rising edge on tick_in
      auto_tick = 1'b0;
      tick_in   = 1'b0;
      repeat (4) step(1, 0, 0, 0);
      tick_in = 1'b1;
      step(1, 0, 0, 0); chk("edge_k",   tick_pulse, 0);
      step(1, 0, 0, 0); chk("edge_k1",  tick_pulse, 0);
      step(1, 0, 0, 0); chk("edge_k2",  tick_pulse, 1);
      step(1, 0, 0, 0); chk("edge_k3",  tick_pulse, 0);
      repeat (3) step(1, 0, 0, 0);
      tick_in = 1'b0;
      repeat (5) begin
         step(1, 0, 0, 0);
         chk("fall_no_pulse", tick_pulse, 0);
      end

      // Basic 5 ms delay with an ignored restart
      auto_tick = 1'b1;
      tick_cnt  = 0;
      step(1, 1, 0, 5);
      chk("basic_busy", busy, 1);
      chk("basic_rem",  remaining, 5);
      prev = 5; decs = 0; injected = 0;
      for (int i = 0; i < 400; i++) begin
         if (decs == 1 && !injected) begin
            injected = 1;
            step(1, 1, 0, 9);
            chk("run_start_ignored", (remaining == 9), 0);
         end else begin
            step(1, 0, 0, 0);
         end
         if (remaining != 16'(prev)) begin
            chk("basic_dec", remaining, prev - 1);
            prev = int'(remaining);
            decs++;
         end
         if (done) break;
      end
      chk("basic_decs", decs, 5);
      chk("basic_done", done, 1);
      chk("basic_done_busy", busy, 0);
      step(1, 0, 0, 0);
      chk("basic_after_done", done, 0);
      chk("basic_after_busy", busy, 0);

      // Zero-duration start
      step(1, 1, 0, 0);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_rem",  remaining, 0);
      step(1, 0, 0, 0);
      chk("zero_done_clr", done, 0);
      chk("zero_busy_clr", busy, 0);

      // Cancel at remaining=2 coinciding with a tick event
      step(1, 1, 0, 4);
      found = 0;
      for (int i = 0; i < 300; i++) begin
         if (m_running && m_rem == 2 && hist[$-1] && !hist[$-2]) begin
            found = 1;
            break;
         end
         step(1, 0, 0, 0);
      end
      chk("cancel_window", found, 1);
      step(1, 0, 1, 0);
      chk("cancel_tick",  tick_pulse, 1);
      chk("cancel_rem",   remaining, 0);
      chk("cancel_busy",  busy, 0);
      chk("cancel_done",  done, 0);
      ndone = 0;
      repeat (40) begin
         step(1, 0, 0, 0);
         if (done) ndone++;
      end
      chk("cancel_no_done", ndone, 0);

`ifdef TIMER_AUTORELOAD_EN
      // Periodic mode: done every 3 ticks
      step(1, 1, 0, 3);
      ndone = 0; nticks = 0;
      for (int i = 0; i < 400 && ndone < 3; i++) begin
         step(1, 0, 0, 0);
         if (tick_pulse) nticks++;
         if (done) begin
            ndone++;
            if (ndone > 1) chk("reload_period", nticks, 3);
            nticks = 0;
         end
      end
      chk("reload_count", ndone, 3);
      step(1, 0, 1, 0);
      repeat (2) step(1, 0, 0, 0);
      chk("reload_cancel_busy", busy, 0);
      chk("reload_cancel_rem",  remaining, 0);
      ndone = 0;
      repeat (80) begin
         step(1, 0, 0, 0);
         if (done) ndone++;
      end
      chk("reload_cancel_no_done", ndone, 0);
`endif

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         bit rn, st, cn;
         int dur;
         rn  = ($urandom % 400) != 0;
         st  = ($urandom % 6) == 0;
         cn  = ($urandom % 60) == 0;
         dur = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 4));
         step(rn, st, cn, dur);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
